wb_copy_master: RTL and testbench

- Wishbone classic-pipelined bus master that copies a block of words from a source address range to a destination address range.
- It is the initiator counterpart to the on-chip Wishbone slave memories. It sits on the J1 system bus alongside the CPU port and is controlled by a start/len/address command interface.
- Data moves in chunks through an internal buffer. Each chunk is a pipelined read burst followed by a pipelined write burst.

---
 rtl/wb_copy_master.sv | 145 ++++++++++++++
 tb/tb_wb_copy_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic-pipelined bus master that copies `len`
// words from src_adr to dst_adr in chunks of up to BUF_DEPTH words. Each
// chunk is a pipelined read burst into an internal buffer, one idle TURN
// cycle, then a pipelined write burst out of the buffer.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                command strobe (only looked at in IDLE)
//   src_adr, dst_adr     first source / destination word address
//   len                  number of words to copy
//   busy                 high in every state except IDLE
//   done                 one-cycle completion pulse
//   wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o   master side of the bus
//   wb_dat_i, wb_ack, wb_stall                slave responses
module wb_copy_master #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int BUF_DEPTH = 8,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    src_adr,
    input  logic [AW-1:0]    dst_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic             wb_we,
    output logic [AW-1:0]    wb_adr,
    output logic [DW-1:0]    wb_dat_o,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic             wb_ack,
    input  logic             wb_stall
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int CW = IW + 1;   // counts 0..BUF_DEPTH inclusive

    typedef enum logic [2:0] {IDLE, RD, TURN, WR, NEXT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    chunk, issued, acked;
    logic [LEN_W-1:0] remaining, rem_nxt;
    logic [AW-1:0]    src_ptr, dst_ptr, adr_q;
    logic [DW-1:0]    buffer [BUF_DEPTH];
    logic             in_burst, issue, ack_ok, last_ack;

    function automatic logic [CW-1:0] min_chunk(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(BUF_DEPTH)) return CW'(BUF_DEPTH);
        else                        return CW'(r);
    endfunction

    assign in_burst = (state == RD) || (state == WR);
    assign issue    = wb_stb && !wb_stall;
    // An ack with nothing outstanding is dropped rather than counted.
    assign ack_ok   = in_burst && wb_ack && (acked != issued);
    assign last_ack = ack_ok && ((acked + 1'b1) == chunk);
    assign rem_nxt  = remaining - LEN_W'(chunk);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len == '0) ? DONE : RD;
            RD:   if (last_ack) state_nxt = TURN;
            TURN: state_nxt = WR;
            WR:   if (last_ack) state_nxt = NEXT;
            NEXT: state_nxt = (rem_nxt == '0) ? DONE : RD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. wb_adr/wb_dat_o only move on an issue, so they stay put
    // while the slave stalls.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        wb_cyc   = in_burst;
        wb_we    = (state == WR);
        wb_stb   = in_burst && (issued < chunk);
        wb_adr   = adr_q;
        wb_dat_o = (state == WR) ? buffer[issued[IW-1:0]] : '0;
    end

    // Counters and pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chunk     <= '0;
            issued    <= '0;
            acked     <= '0;
            remaining <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            adr_q     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_ptr   <= src_adr;
                    dst_ptr   <= dst_adr;
                    adr_q     <= src_adr;
                    remaining <= len;
                    chunk     <= min_chunk(len);
                    issued    <= '0;
                    acked     <= '0;
                end
                RD, WR: begin
                    if (issue) begin
                        adr_q  <= adr_q + 1'b1;
                        issued <= issued + 1'b1;
                    end
                    if (ack_ok) acked <= acked + 1'b1;
                end
                TURN: begin
                    adr_q  <= dst_ptr;
                    issued <= '0;
                    acked  <= '0;
                end
                NEXT: begin
                    remaining <= rem_nxt;
                    src_ptr   <= src_ptr + AW'(chunk);
                    dst_ptr   <= dst_ptr + AW'(chunk);
                    adr_q     <= src_ptr + AW'(chunk);
                    chunk     <= min_chunk(rem_nxt);
                    issued    <= '0;
                    acked     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Chunk buffer, filled in ack order during RD
    always_ff @(posedge clk) begin
        if (state == RD && ack_ok) buffer[acked[IW-1:0]] <= wb_dat_i;
    end
endmodule

// File: tb/tb_wb_copy_master.sv
module tb_wb_copy_master;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] src_adr, dst_adr, len;
    logic        busy, done, wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;
    logic [15:0] wb_adr, wb_dat_o, wb_dat_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_copy_master #(.AW(16), .DW(16), .BUF_DEPTH(8), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_adr(src_adr),
        .dst_adr(dst_adr), .len(len), .busy(busy), .done(done),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
        .wb_stall(wb_stall)
    );

    // Slave RAM with configurable ack latency and optional alternating stall
    logic [15:0] mem [0:65535];
    logic        pvld [0:7];
    logic [15:0] padr [0:7];
    logic        pl_en = 1'b0;
    logic [15:0] pl_adr = '0, pl_dat = '0;
    int          lat = 1;
    logic        stall_mode = 1'b0;
    logic        stall_t = 1'b0;
    logic        accept;

    assign wb_stall = stall_mode & stall_t;
    assign accept   = wb_cyc & wb_stb & ~wb_stall;
    assign wb_ack   = pvld[0];
    assign wb_dat_i = pvld[0] ? mem[padr[0]] : 16'h0000;

    always @(posedge clk) begin
        stall_t <= ~stall_t;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pvld[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                pvld[i] <= pvld[i+1];
                padr[i] <= padr[i+1];
            end
            pvld[7] <= 1'b0;
            if (accept) begin
                pvld[lat-1] <= 1'b1;
                padr[lat-1] <= wb_adr;
            end
        end
        if (accept && wb_we) mem[wb_adr] <= wb_dat_o;
        if (pl_en) mem[pl_adr] <= pl_dat;
    end

    // Bus monitor: issue logs, ack counts, stall-hold and unsolicited-ack tracking
    logic [15:0] rd_log [0:255];
    logic [15:0] wr_log [0:255];
    int rd_n = 0, wr_n = 0, rdack_n = 0, wrack_n = 0, done_cnt = 0;
    int hold_err = 0, unsol = 0, outst = 0, cyc_seen = 0;
    logic        prev_hold = 1'b0, p_we = 1'b0;
    logic [15:0] p_adr = '0, p_dat = '0;

    always @(posedge clk) begin
        if (accept && wb_we)  begin wr_log[wr_n[7:0]] <= wb_adr; wr_n <= wr_n + 1; end
        if (accept && !wb_we) begin rd_log[rd_n[7:0]] <= wb_adr; rd_n <= rd_n + 1; end
        if (wb_ack && wb_we)  wrack_n <= wrack_n + 1;
        if (wb_ack && !wb_we) rdack_n <= rdack_n + 1;
        if (done)   done_cnt <= done_cnt + 1;
        if (wb_cyc) cyc_seen <= cyc_seen + 1;
        if (prev_hold && (wb_adr !== p_adr || wb_we !== p_we || wb_dat_o !== p_dat))
            hold_err <= hold_err + 1;
        if (wb_ack && outst == 0) unsol <= unsol + 1;
        if (!rst_n) outst <= 0;
        else        outst <= outst + int'(accept) - int'(wb_ack && outst != 0);
        prev_hold <= rst_n & wb_stb & wb_stall;
        p_adr <= wb_adr; p_we <= wb_we; p_dat <= wb_dat_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        int n;
        @(negedge clk);
        start = 1'b1; src_adr = s; dst_adr = d; len = l;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk("copy_timeout", 32'(n < 3000), 32'd1);
        @(negedge clk);
    endtask

    int b_rd, b_wr, b_ra, b_wa, b_dn, b_cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_adr", wb_adr, 16'h0);
        chk("rst_dat", wb_dat_o, 16'h0);
        rst_n = 1'b1;

        // Basic 3-word copy, cycle-exact timing
        preload(16'h0010, 16'hA001);
        preload(16'h0011, 16'hA002);
        preload(16'h0012, 16'hA003);
        b_rd = rd_n; b_dn = done_cnt;
        @(negedge clk);
        start = 1'b1; src_adr = 16'h0010; dst_adr = 16'h0040; len = 16'd3;  // cycle 0
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t1_done_c%0d", c), done, 32'(c == 11));
            if (c <= 10) chk($sformatf("t1_busy_c%0d", c), busy, 1'b1);
            if (c == 12) chk("t1_busy_c12", busy, 1'b0);
            if (c <= 10) chk($sformatf("t1_cyc_c%0d", c), wb_cyc, 32'(c != 5 && c != 10));
        end
        chk("t1_mem40", mem[16'h0040], 16'hA001);
        chk("t1_mem41", mem[16'h0041], 16'hA002);
        chk("t1_mem42", mem[16'h0042], 16'hA003);
        chk("t1_rdadr0", rd_log[b_rd[7:0]], 16'h0010);
        chk("t1_rdadr2", rd_log[8'(b_rd + 2)], 16'h0012);
        chk("t1_done_cnt", done_cnt - b_dn, 1);

        // len = 0: no bus activity, done in cycle 1
        b_cyc = cyc_seen;
        @(negedge clk);
        start = 1'b1; len = 16'd0; src_adr = 16'h0010; dst_adr = 16'h0050;
        @(negedge clk);
        start = 1'b0;
        chk("t2_busy_c1", busy, 1'b1);
        chk("t2_done_c1", done, 1'b1);
        chk("t2_cyc_c1", wb_cyc, 1'b0);
        @(negedge clk);
        chk("t2_busy_c2", busy, 1'b0);
        chk("t2_done_c2", done, 1'b0);
        chk("t2_no_cyc", cyc_seen - b_cyc, 0);

        // len = 20: chunks 8, 8, 4
        for (int i = 0; i < 20; i++) preload(16'h0200 + 16'(i), 16'h3C00 + 16'(i * 7));
        b_rd = rd_n; b_wr = wr_n; b_ra = rdack_n; b_wa = wrack_n; b_dn = done_cnt;
        run_copy(16'h0200, 16'h0300, 16'd20);
        chk("t3_rd_issues", rd_n - b_rd, 20);
        chk("t3_wr_issues", wr_n - b_wr, 20);
        chk("t3_rd_acks", rdack_n - b_ra, 20);
        chk("t3_wr_acks", wrack_n - b_wa, 20);
        chk("t3_done_cnt", done_cnt - b_dn, 1);
        for (int i = 0; i < 20; i++)
            chk($sformatf("t3_mem%0d", i), mem[16'h0300 + 16'(i)], 16'h3C00 + 16'(i * 7));

        // Alternating stall, ack latency 3
        lat = 3; stall_mode = 1'b1;
        for (int i = 0; i < 5; i++) preload(16'h0500 + 16'(i), 16'h9100 + 16'(i));
        b_rd = rd_n; b_wr = wr_n;
        run_copy(16'h0500, 16'h0600, 16'd5);
        chk("t4_rd_issues", rd_n - b_rd, 5);
        chk("t4_wr_issues", wr_n - b_wr, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_rdadr%0d", i), rd_log[8'(b_rd + i)], 16'h0500 + 16'(i));
            chk($sformatf("t4_wradr%0d", i), wr_log[8'(b_wr + i)], 16'h0600 + 16'(i));
            chk($sformatf("t4_mem%0d", i), mem[16'h0600 + 16'(i)], 16'h9100 + 16'(i));
        end
        chk("t4_hold", hold_err, 0);
        lat = 1; stall_mode = 1'b0;

        // Address wrap
        preload(16'hFFFE, 16'h1111);
        preload(16'hFFFF, 16'h2222);
        preload(16'h0000, 16'h3333);
        preload(16'h0001, 16'h4444);
        b_rd = rd_n; b_wr = wr_n;
        run_copy(16'hFFFE, 16'h0100, 16'd4);
        chk("t5_rd0", rd_log[8'(b_rd + 0)], 16'hFFFE);
        chk("t5_rd1", rd_log[8'(b_rd + 1)], 16'hFFFF);
        chk("t5_rd2", rd_log[8'(b_rd + 2)], 16'h0000);
        chk("t5_rd3", rd_log[8'(b_rd + 3)], 16'h0001);
        chk("t5_wr0", wr_log[8'(b_wr + 0)], 16'h0100);
        chk("t5_wr3", wr_log[8'(b_wr + 3)], 16'h0103);
        chk("t5_mem100", mem[16'h0100], 16'h1111);
        chk("t5_mem103", mem[16'h0103], 16'h4444);

        // Reset during WR of a len=8 copy
        for (int i = 0; i < 8; i++) preload(16'h0700 + 16'(i), 16'h7700 + 16'(i));
        preload(16'h0903, 16'h1234);
        b_dn = done_cnt;
        @(negedge clk);
        start = 1'b1; src_adr = 16'h0700; dst_adr = 16'h0800; len = 16'd8;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!(wb_cyc && wb_we) && n < 200) begin @(negedge clk); n++; end
            chk("t6_reach_wr", 32'(n < 200), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_cyc_after_rst", wb_cyc, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_no_done", done_cnt - b_dn, 0);

        // New copy completes; a start while busy is ignored
        b_wr = wr_n; b_dn = done_cnt;
        @(negedge clk);
        start = 1'b1; src_adr = 16'h0010; dst_adr = 16'h0900; len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; src_adr = 16'h0700; dst_adr = 16'h0A00; len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!done && n < 200) begin @(negedge clk); n++; end
            chk("t6_done_seen", 32'(n < 200), 32'd1);
        end
        repeat (10) @(negedge clk);
        chk("t6_wr_issues", wr_n - b_wr, 3);
        chk("t6_done_cnt", done_cnt - b_dn, 1);
        chk("t6_mem900", mem[16'h0900], 16'hA001);
        chk("t6_mem902", mem[16'h0902], 16'hA003);
        chk("t6_mem903", mem[16'h0903], 16'h1234);
        chk("t6_idle", busy, 1'b0);
        chk("unsolicited_acks", unsol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
